// File: rtl/dmi_responder.sv
// DMI target endpoint: takes one DMI request at a time, runs a single-beat access on
// the register port with an ack timeout, and returns a status/data response.
module dmi_responder #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [6:0]  ADDR_LO = 7'h04,
  parameter logic [6:0]  ADDR_HI = 7'h5F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        debug_req_valid,
  output logic        debug_req_ready,
  input  logic [6:0]  debug_req_bits_addr,
  input  logic [1:0]  debug_req_bits_op,
  input  logic [31:0] debug_req_bits_data,
  output logic        debug_resp_valid,
  input  logic        debug_resp_ready,
  output logic [1:0]  debug_resp_bits_resp,
  output logic [31:0] debug_resp_bits_data,
  output logic        reg_en,
  output logic        reg_we,
  output logic [6:0]  reg_addr,
  output logic [31:0] reg_wdata,
  input  logic        reg_ack,
  input  logic [31:0] reg_rdata,
  input  logic        reg_err
);

  // state  | meaning
  // IDLE   | ready for a new request
  // ACCESS | register access in flight, waiting for reg_ack or timeout
  // RESP   | response presented until the initiator takes it
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0]  RESP_OK   = 2'd0;
  localparam logic [1:0]  RESP_FAIL = 2'd2;
  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [15:0] cnt, cnt_nx;
  logic [1:0]  resp_q, resp_nx;
  logic [31:0] data_q, data_nx;
  logic        load;
  logic        accept;
  logic        mapped;

  assign debug_req_ready = (state == IDLE) && !reset;
  assign accept          = debug_req_valid && debug_req_ready;
  assign mapped          = (debug_req_bits_addr >= ADDR_LO) && (debug_req_bits_addr <= ADDR_HI);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    resp_nx  = resp_q;
    data_nx  = data_q;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load   = 1'b1;
          cnt_nx = '0;
          if (debug_req_bits_op == 2'd0) begin
            state_nx = RESP;
            resp_nx  = RESP_OK;
            data_nx  = '0;
          end else if (debug_req_bits_op == 2'd3 || !mapped) begin
            state_nx = RESP;
            resp_nx  = RESP_FAIL;
            data_nx  = '0;
          end else begin
            state_nx = ACCESS;
          end
        end
      end
      ACCESS: begin
        // ack takes priority over a timeout landing in the same cycle
        if (reg_ack) begin
          state_nx = RESP;
          resp_nx  = reg_err ? RESP_FAIL : RESP_OK;
          data_nx  = we_q ? 32'd0 : reg_rdata;
        end else if (cnt == CNT_LAST) begin
          state_nx = RESP;
          resp_nx  = RESP_FAIL;
          data_nx  = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      RESP: begin
        if (debug_resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      resp_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      resp_q <= resp_nx;
      data_q <= data_nx;
      if (load) begin
        addr_q  <= debug_req_bits_addr;
        we_q    <= (debug_req_bits_op == 2'd2);
        wdata_q <= debug_req_bits_data;
      end
    end
  end

  assign reg_en               = (state == ACCESS);
  assign reg_we               = reg_en && we_q;
  assign reg_addr             = addr_q;
  assign reg_wdata            = wdata_q;
  assign debug_resp_valid     = (state == RESP);
  assign debug_resp_bits_resp = resp_q;
  assign debug_resp_bits_data = data_q;

endmodule
